// File: rtl/usb_ctrl_regs_writer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// usb_ctrl_regs_writer: decodes 4D-framed register writes/read requests from USB
// Revision: 1.0
// -----------------------------------------------------------------------------
module usb_ctrl_regs_writer #(
  parameter logic [7:0]  SYS_TIME_ADDR = 8'h01,
  parameter logic [7:0]  SDI_ADDR      = 8'h02,
  parameter logic [7:0]  CSI_ADDR      = 8'h03,
  parameter int unsigned TIMEOUT       = 1000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  output logic [63:0] o_st_bytes,
  output logic        o_st_wr,
  output logic [15:0] o_sdi_bytes,
  output logic        o_sdi_wr,
  output logic [23:0] o_csi_bytes,
  output logic        o_csi_wr,
  output logic        o_st_rdreq,
  output logic        o_rdreq,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam logic [7:0] c_SYNC  = 8'h4D;
  localparam int         c_GAP_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN_H = 3'd2,
    S_LEN_L = 3'd3,
    S_DATA  = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [7:0]         r_addr, w_addr_nxt;
  logic [2:0]         r_cnt, w_cnt_nxt;
  // Together with the incoming byte this forms the 64-bit shadow; the oldest
  // byte would shift out on the final accept, so it is never stored.
  logic [55:0]        r_shadow, w_shadow_nxt;
  logic [c_GAP_W-1:0] r_gap, w_gap_nxt;
  logic [63:0]        w_word;
  logic [3:0]         w_exp_len;
  logic               w_addr_ok;
  logic               w_st_wr, w_sdi_wr, w_csi_wr, w_st_rdreq, w_rdreq, w_err;

  assign w_word    = {r_shadow, i_rx_byte};
  assign w_addr_ok = (i_rx_byte == SYS_TIME_ADDR) || (i_rx_byte == SDI_ADDR) ||
                     (i_rx_byte == CSI_ADDR);
  assign w_exp_len = (r_addr == SYS_TIME_ADDR) ? 4'd8 :
                     (r_addr == SDI_ADDR)      ? 4'd2 : 4'd3;
  assign o_busy    = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_gap_nxt    = r_gap;
    w_st_wr      = 1'b0;
    w_sdi_wr     = 1'b0;
    w_csi_wr     = 1'b0;
    w_st_rdreq   = 1'b0;
    w_rdreq      = 1'b0;
    w_err        = 1'b0;
    if (i_rx_valid) begin
      w_gap_nxt = '0;
      case (r_state)
        S_IDLE: begin
          if (i_rx_byte == c_SYNC) w_state_nxt = S_ADDR;
        end
        S_ADDR: begin
          if (w_addr_ok) begin
            w_addr_nxt  = i_rx_byte;
            w_state_nxt = S_LEN_H;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_LEN_H: begin
          if (i_rx_byte == 8'd0) begin
            w_state_nxt = S_LEN_L;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_LEN_L: begin
          w_state_nxt = S_IDLE;
          if (i_rx_byte == 8'd0) begin
            if (r_addr == SYS_TIME_ADDR) w_st_rdreq = 1'b1;
            else                         w_rdreq    = 1'b1;
          end else if (i_rx_byte == {4'd0, w_exp_len}) begin
            w_state_nxt  = S_DATA;
            w_cnt_nxt    = '0;
            w_shadow_nxt = '0;
          end else begin
            w_err = 1'b1;
          end
        end
        S_DATA: begin
          w_shadow_nxt = w_word[55:0];
          w_cnt_nxt    = r_cnt + 3'd1;
          if ({1'b0, r_cnt} == (w_exp_len - 4'd1)) begin
            w_state_nxt = S_IDLE;
            if (r_addr == SYS_TIME_ADDR) w_st_wr  = 1'b1;
            else if (r_addr == SDI_ADDR) w_sdi_wr = 1'b1;
            else                         w_csi_wr = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (r_state != S_IDLE) begin
      if (r_gap == c_GAP_W'(TIMEOUT - 1)) begin
        w_gap_nxt   = '0;
        w_err       = 1'b1;
        w_state_nxt = S_IDLE;
      end else begin
        w_gap_nxt = r_gap + c_GAP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_gap       <= '0;
      o_st_bytes  <= '0;
      o_sdi_bytes <= '0;
      o_csi_bytes <= '0;
      o_st_wr     <= 1'b0;
      o_sdi_wr    <= 1'b0;
      o_csi_wr    <= 1'b0;
      o_st_rdreq  <= 1'b0;
      o_rdreq     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shadow    <= w_shadow_nxt;
      r_gap       <= w_gap_nxt;
      o_st_wr     <= w_st_wr;
      o_sdi_wr    <= w_sdi_wr;
      o_csi_wr    <= w_csi_wr;
      o_st_rdreq  <= w_st_rdreq;
      o_rdreq     <= w_rdreq;
      o_frame_err <= w_err;
      // Buses move in the same edge as their strobe so they are valid with it.
      if (w_st_wr)  o_st_bytes  <= w_word;
      if (w_sdi_wr) o_sdi_bytes <= w_word[15:0];
      if (w_csi_wr) o_csi_bytes <= w_word[23:0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_ctrl_regs_writer.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_usb_ctrl_regs_writer: directed + randomized frames against a frame-level model
// Revision: 1.0
// -----------------------------------------------------------------------------
module tb_usb_ctrl_regs_writer;

  localparam int unsigned TMO = 1000;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [63:0] st_bytes;
  logic [15:0] sdi_bytes;
  logic [23:0] csi_bytes;
  logic        st_wr, sdi_wr, csi_wr, st_rdreq, rdreq, frame_err, busy;

  always #5 clk = ~clk;

  usb_ctrl_regs_writer #(
    .SYS_TIME_ADDR(8'h01), .SDI_ADDR(8'h02), .CSI_ADDR(8'h03), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_rx_byte(rx_byte), .i_rx_valid(rx_valid),
    .o_st_bytes(st_bytes), .o_st_wr(st_wr), .o_sdi_bytes(sdi_bytes), .o_sdi_wr(sdi_wr),
    .o_csi_bytes(csi_bytes), .o_csi_wr(csi_wr), .o_st_rdreq(st_rdreq), .o_rdreq(rdreq),
    .o_frame_err(frame_err), .o_busy(busy)
  );

  // Event kinds: 0 st_wr, 1 sdi_wr, 2 csi_wr, 3 st_rdreq, 4 rdreq, 5 frame_err
  typedef struct { int kind; logic [63:0] val; } ev_t;
  typedef logic [7:0] bq_t [$];

  ev_t         got_q[$];
  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] m_st;
  logic [15:0] m_sdi;
  logic [23:0] m_csi;
  logic [5:0]  mon_p;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    mon_p = {frame_err, rdreq, st_rdreq, csi_wr, sdi_wr, st_wr};
    if (mon_p != 6'd0) begin
      check("one_pulse", 64'($countones(mon_p)), 64'd1);
      if (st_wr)     got_q.push_back('{0, st_bytes});
      if (sdi_wr)    got_q.push_back('{1, 64'(sdi_bytes)});
      if (csi_wr)    got_q.push_back('{2, 64'(csi_bytes)});
      if (st_rdreq)  got_q.push_back('{3, 64'd0});
      if (rdreq)     got_q.push_back('{4, 64'd0});
      if (frame_err) got_q.push_back('{5, 64'd0});
    end
  end

  // Frame-level parser over a whole byte stream; a trailing partial frame
  // yields an error only if the stream was followed by a timeout.
  function automatic void model(input bq_t q, input bit timed_out);
    int i = 0;
    int n = q.size();
    int e, len;
    bit partial = 0;
    logic [7:0]  a;
    logic [63:0] v;
    while (i < n && !partial) begin
      if (q[i] != 8'h4D) i++;
      else if (i + 1 >= n) partial = 1;
      else begin
        a = q[i+1];
        e = (a == 8'h01) ? 8 : (a == 8'h02) ? 2 : (a == 8'h03) ? 3 : -1;
        if (e < 0) begin exp_q.push_back('{5, 64'd0}); i += 2; end
        else if (i + 2 >= n) partial = 1;
        else if (q[i+2] != 8'h00) begin exp_q.push_back('{5, 64'd0}); i += 3; end
        else if (i + 3 >= n) partial = 1;
        else begin
          len = int'(q[i+3]);
          if (len == 0) begin
            exp_q.push_back('{(a == 8'h01) ? 3 : 4, 64'd0});
            i += 4;
          end else if (len != e) begin
            exp_q.push_back('{5, 64'd0});
            i += 4;
          end else if (i + 4 + e > n) partial = 1;
          else begin
            v = 64'd0;
            for (int k = 0; k < e; k++) v = (v << 8) | 64'(q[i+4+k]);
            if (a == 8'h01)      m_st  = v;
            else if (a == 8'h02) m_sdi = v[15:0];
            else                 m_csi = v[23:0];
            exp_q.push_back('{e == 8 ? 0 : (e == 2 ? 1 : 2), v});
            i += 4 + e;
          end
        end
      end
    end
    if (partial && timed_out) exp_q.push_back('{5, 64'd0});
  endfunction

  task automatic drive(input logic v, input logic [7:0] b);
    @(negedge clk);
    rx_valid = v;
    rx_byte  = b;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'($urandom));
  endtask

  task automatic send(input bq_t q, input int max_gap);
    foreach (q[k]) begin
      if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
      drive(1'b1, q[k]);
    end
  endtask

  task automatic settle_check(input string tag);
    idle(3);
    check({tag, "_nev"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      check({tag, "_kind"}, 64'(got_q[k].kind), 64'(exp_q[k].kind));
      check({tag, "_val"}, got_q[k].val, exp_q[k].val);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_st_bus"}, st_bytes, m_st);
    check({tag, "_sdi_bus"}, 64'(sdi_bytes), 64'(m_sdi));
    check({tag, "_csi_bus"}, 64'(csi_bytes), 64'(m_csi));
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  function automatic void gen_frame(inout bq_t q);
    int          sel = int'($urandom_range(6, 0));
    logic [7:0]  a = 8'($urandom_range(3, 1));
    int          e = (a == 8'h01) ? 8 : (a == 8'h02) ? 2 : 3;
    logic [7:0]  b;
    case (sel)
      3: begin q.push_back(8'h4D); q.push_back(a); q.push_back(8'h00); q.push_back(8'h00); end
      4: begin
        b = 8'($urandom);
        if (b >= 8'h01 && b <= 8'h03) b = 8'h90;
        q.push_back(8'h4D); q.push_back(b);
      end
      5: begin q.push_back(8'h4D); q.push_back(a); q.push_back(8'($urandom_range(255, 1))); end
      6: begin
        q.push_back(8'h4D); q.push_back(a); q.push_back(8'h00);
        q.push_back(8'($urandom_range(255, 9)));
      end
      default: begin
        q.push_back(8'h4D); q.push_back(a); q.push_back(8'h00); q.push_back(8'(e));
        for (int k = 0; k < e; k++)
          q.push_back(($urandom_range(3, 0) == 0) ? 8'h4D : 8'($urandom));
      end
    endcase
    for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
      b = 8'($urandom);
      q.push_back((b == 8'h4D) ? 8'h5E : b);
    end
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t q, q2;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    n_rst    = 1'b0;
    m_st = '0; m_sdi = '0; m_csi = '0;
    repeat (3) @(negedge clk);
    check("rst_st_bus", st_bytes, 64'd0);
    check("rst_sdi_bus", 64'(sdi_bytes), 64'd0);
    check("rst_csi_bus", 64'(csi_bytes), 64'd0);
    check("rst_pulses", 64'({st_wr, sdi_wr, csi_wr, st_rdreq, rdreq, frame_err}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    n_rst = 1'b1;

    // System-time write with exact strobe latency
    q = {8'h4D, 8'h01, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send(q, 0);
    drive(1'b0, 8'h00);
    check("st_wr_lat", 64'(st_wr), 64'd1);
    check("st_bus_lat", st_bytes, 64'h1122334455667788);
    drive(1'b0, 8'h00);
    check("st_wr_drop", 64'(st_wr), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    model(q, 0);
    settle_check("st_write");

    q = {8'h4D, 8'h02, 8'h00, 8'h02, 8'h4D, 8'h5E,
         8'h4D, 8'h03, 8'h00, 8'h03, 8'hA1, 8'hB2, 8'hC3};
    send(q, 0); model(q, 0); settle_check("b2b");

    q = {8'h4D, 8'h01, 8'h00, 8'h00, 8'h4D, 8'h03, 8'h00, 8'h00};
    send(q, 0); model(q, 0); settle_check("rdreq");

    q = {8'h4D, 8'h07, 8'h5E, 8'h4D, 8'h02, 8'h01, 8'h5E, 8'h4D, 8'h02, 8'h00, 8'h05};
    send(q, 0); model(q, 0); settle_check("errs");

    // Timeout mid-frame, then a good frame
    q = {8'h4D, 8'h02, 8'h00, 8'h02, 8'hAA};
    send(q, 0); idle(TMO); model(q, 1);
    q2 = {8'h4D, 8'h02, 8'h00, 8'h02, 8'h12, 8'h34};
    send(q2, 0); model(q2, 0); settle_check("timeout");

    // One cycle short of the timeout: the byte still belongs to the frame
    q = {8'h4D, 8'h02, 8'h00, 8'h02, 8'h56};
    send(q, 0); idle(int'(TMO) - 1);
    q2 = {8'h78};
    send(q2, 0);
    q.push_back(8'h78);
    model(q, 0); settle_check("no_timeout");

    // Asynchronous reset mid-DATA
    q = {8'h4D, 8'h01, 8'h00, 8'h08, 8'h11, 8'h22, 8'h33};
    send(q, 0);
    drive(1'b0, 8'h00);
    check("busy_mid", 64'(busy), 64'd1);
    #2 n_rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_st_bus", st_bytes, 64'd0);
    check("arst_sdi_bus", 64'(sdi_bytes), 64'd0);
    check("arst_csi_bus", 64'(csi_bytes), 64'd0);
    check("arst_pulses", 64'({st_wr, sdi_wr, csi_wr, st_rdreq, rdreq, frame_err}), 64'd0);
    m_st = '0; m_sdi = '0; m_csi = '0;
    @(negedge clk);
    n_rst = 1'b1;
    q = {8'h5E, 8'h5E};
    send(q, 0); model(q, 0); settle_check("post_rst");

    // Randomized frame batches with random inter-byte gaps
    for (int batch = 0; batch < 10; batch++) begin
      q.delete();
      for (int f = 0; f < 5; f++) gen_frame(q);
      send(q, 3);
      model(q, 0);
      settle_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
